// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for alu_seq.
//   Request : in_valid, in_ready, oc, a, b
//   Response: out_valid, out_ready, f, r, z, n, c, v, dz
//   master = requester/consumer side, slave = alu_seq side.
interface alu_seq_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            oc;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] f;
  logic [DATA_WIDTH-1:0] r;
  logic                  z;
  logic                  n;
  logic                  c;
  logic                  v;
  logic                  dz;

  modport master (
    output in_valid, oc, a, b, out_ready,
    input  in_ready, out_valid, f, r, z, n, c, v, dz
  );

  modport slave (
    input  in_valid, oc, a, b, out_ready,
    output in_ready, out_valid, f, r, z, n, c, v, dz
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle 8-op ALU with iterative restoring divider.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_seq_if.slave (in_valid/in_ready/oc/a/b request,
//          out_valid/out_ready/f/r/z/n/c/v/dz response)
// Optional feature macro: ALU_SEQ_REMAINDER_EN (drives DIV remainder on r).
// Every op spends one cycle in DONE with out_valid low while the result is
// computed from the latched operands and registered; DIV first spends
// DATA_WIDTH cycles in the DIV state producing one quotient bit per cycle.
module alu_seq #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     oc_q, oc_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   acc_q, acc_d, quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   f_q, f_d, r_q, r_d;
  logic           z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, dz_q, dz_d;

  // divider step
  logic [W:0]     rem_shift, trial;
  logic           trial_ok;

  // result of the latched operation
  logic [W:0]     sum, diff;
  logic [W2-1:0]  prod;
  logic [W-1:0]   res_f;
  logic           res_c, res_v, res_dz;
`ifdef ALU_SEQ_REMAINDER_EN
  logic [W-1:0]   res_r;
`endif

  // Restoring division: shift {acc,quo} left, keep the trial difference if it did not borrow.
  always_comb begin
    rem_shift = {acc_q, quo_q[W-1]};
    trial     = rem_shift - {1'b0, b_q};
    trial_ok  = ~trial[W];
  end

  // Result and flags from latched operands (DIV uses the finished divider state).
  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
    prod   = W2'(a_q) * W2'(b_q);
    res_f  = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_dz = 1'b0;
`ifdef ALU_SEQ_REMAINDER_EN
    res_r  = '0;
`endif
    case (oc_q)
      OP_ADD: begin
        res_f = sum[W-1:0];
        res_c = sum[W];
        res_v = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        res_f = diff[W-1:0];
        res_c = diff[W];
        res_v = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      OP_MUL: begin
        res_f = prod[W-1:0];
        res_c = |prod[W2-1:W];
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_dz = 1'b1;
        end else begin
          res_f = quo_q;
`ifdef ALU_SEQ_REMAINDER_EN
          res_r = acc_q;
`endif
        end
      end
      OP_NOT:  res_f = ~a_q;
      OP_XOR:  res_f = a_q ^ b_q;
      OP_OR:   res_f = a_q | b_q;
      default: res_f = a_q & b_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, datapath and registered outputs.
  always_comb begin
    state_d     = state_q;
    oc_d        = oc_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    f_d         = f_q;
    r_d         = r_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    dz_d        = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          oc_d = bus.oc;
          a_d  = bus.a;
          b_d  = bus.b;
          if (bus.oc == OP_DIV && bus.b != '0) begin
            acc_d   = '0;
            quo_d   = bus.a;
            cnt_d   = CW'(W);
            state_d = DIV;
          end else begin
            state_d = DONE;
          end
        end
      end
      DIV: begin
        acc_d = trial_ok ? trial[W-1:0] : rem_shift[W-1:0];
        quo_d = {quo_q[W-2:0], trial_ok};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          f_d  = res_f;
`ifdef ALU_SEQ_REMAINDER_EN
          r_d  = res_r;
`else
          r_d  = '0;
`endif
          z_d  = (res_f == '0);
          n_d  = res_f[W-1];
          c_d  = res_c;
          v_d  = res_v;
          dz_d = res_dz;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      r_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      oc_q        <= oc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      r_q         <= r_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      dz_q        <= dz_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.r         = r_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.dz        = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (DATA_WIDTH=16).
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_seq_if #(.DATA_WIDTH(16)) bus ();
  alu_seq #(.DATA_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Expected remainder depends on the build option.
  function automatic logic [15:0] exp_rem(input logic [15:0] rem);
`ifdef ALU_SEQ_REMAINDER_EN
    return rem;
`else
    return 16'h0000 & rem;
`endif
  endfunction

  // Issue one request, return cycles from accept edge to out_valid and whether in_ready stayed low.
  task automatic send(input logic [2:0] op, input logic [15:0] aa, input logic [15:0] bb,
                      output int lat, output logic rdy_low);
    int k;
    bus.oc = op; bus.a = aa; bus.b = bb; bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff(input string nm);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_handoff got ov=%b ir=%b want ov=0 ir=1", nm, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({bus.out_valid, bus.z, bus.n, bus.c, bus.v, bus.dz} !== 6'b0 || bus.f !== 16'h0 || bus.r !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got ov=%b f=%h r=%h flags=%b want all 0", bus.out_valid, bus.f, bus.r,
               {bus.z, bus.n, bus.c, bus.v, bus.dz});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  // ADD/SUB/MUL/logic table: op, a, b, f, {z,n,c,v,dz}
  task automatic test_single_cycle_ops();
    logic [2:0]  ops [8] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111, 3'b100};
    logic [15:0] as  [8] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0100, 16'h1234, 16'h00F0, 16'hFF0F, 16'h00FF};
    logic [15:0] bs  [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0100, 16'h1234, 16'h0F00, 16'h0FF0, 16'hAAAA};
    logic [15:0] fs  [8] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0FF0, 16'h0F00, 16'hFF00};
    logic [4:0]  fl  [8] = '{5'b10100, 5'b01010, 5'b00010, 5'b10100, 5'b10000, 5'b00000, 5'b00000, 5'b01000};
    int lat;
    logic rl;
    for (int i = 0; i < 8; i++) begin
      send(ops[i], as[i], bs[i], lat, rl);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL op%0d_latency got %0d want 1", i, lat); end
      n_cmp++;
      if (bus.f !== fs[i]) begin n_bad++; $display("FAIL op%0d_f got %h want %h", i, bus.f, fs[i]); end
      n_cmp++;
      if ({bus.z, bus.n, bus.c, bus.v, bus.dz} !== fl[i]) begin
        n_bad++; $display("FAIL op%0d_flags got %b want %b", i, {bus.z, bus.n, bus.c, bus.v, bus.dz}, fl[i]);
      end
      n_cmp++;
      if (bus.r !== 16'h0) begin n_bad++; $display("FAIL op%0d_r got %h want 0", i, bus.r); end
      handoff("op");
    end
  endtask

  // DIV table: a, b, quotient, remainder, {z,n,c,v,dz}
  task automatic test_div();
    logic [15:0] as [3] = '{16'd100, 16'd5, 16'hFFFF};
    logic [15:0] bs [3] = '{16'd7, 16'd9, 16'h0001};
    logic [15:0] qs [3] = '{16'd14, 16'd0, 16'hFFFF};
    logic [15:0] rs [3] = '{16'd2, 16'd5, 16'd0};
    logic [4:0]  fl [3] = '{5'b00000, 5'b10000, 5'b01000};
    int lat;
    logic rl;
    for (int i = 0; i < 3; i++) begin
      send(3'b011, as[i], bs[i], lat, rl);
      n_cmp++;
      if (lat !== 17) begin n_bad++; $display("FAIL div%0d_latency got %0d want 17", i, lat); end
      n_cmp++;
      if (rl !== 1'b1) begin n_bad++; $display("FAIL div%0d_in_ready got high want low", i); end
      n_cmp++;
      if (bus.f !== qs[i]) begin n_bad++; $display("FAIL div%0d_q got %0d want %0d", i, bus.f, qs[i]); end
      n_cmp++;
      if (bus.r !== exp_rem(rs[i])) begin
        n_bad++; $display("FAIL div%0d_r got %0d want %0d", i, bus.r, exp_rem(rs[i]));
      end
      n_cmp++;
      if ({bus.z, bus.n, bus.c, bus.v, bus.dz} !== fl[i]) begin
        n_bad++; $display("FAIL div%0d_flags got %b want %b", i, {bus.z, bus.n, bus.c, bus.v, bus.dz}, fl[i]);
      end
      handoff("div");
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic rl;
    send(3'b011, 16'h1234, 16'h0000, lat, rl);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL divz_latency got %0d want 1", lat); end
    n_cmp++;
    if (bus.f !== 16'h0 || bus.r !== 16'h0) begin
      n_bad++; $display("FAIL divz_fr got f=%h r=%h want 0 0", bus.f, bus.r);
    end
    n_cmp++;
    if ({bus.z, bus.n, bus.c, bus.v, bus.dz} !== 5'b10001) begin
      n_bad++; $display("FAIL divz_flags got %b want 10001", {bus.z, bus.n, bus.c, bus.v, bus.dz});
    end
    handoff("divz");
  endtask

  task automatic test_backpressure();
    int lat;
    logic rl;
    send(3'b101, 16'hF0F0, 16'h0FF0, lat, rl);
    n_cmp++;
    if (bus.n !== 1'b1) begin n_bad++; $display("FAIL bp_n got %b want 1", bus.n); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.f !== 16'hFF00 || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d got ov=%b f=%h ir=%b want ov=1 f=ff00 ir=0", i, bus.out_valid, bus.f, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    handoff("bp");
  endtask

  task automatic test_reset_mid_div();
    int lat;
    logic rl;
    bus.oc = 3'b011; bus.a = 16'd100; bus.b = 16'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.z, bus.n, bus.c, bus.v, bus.dz} !== 6'b0 || bus.f !== 16'h0 || bus.r !== 16'h0) begin
      n_bad++;
      $display("FAIL rstdiv_outputs got ov=%b f=%h r=%h flags=%b want all 0", bus.out_valid, bus.f, bus.r,
               {bus.z, bus.n, bus.c, bus.v, bus.dz});
    end
    #20;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstdiv_in_ready got %b want 1", bus.in_ready); end
    send(3'b000, 16'd3, 16'd4, lat, rl);
    n_cmp++;
    if (lat !== 1 || bus.f !== 16'd7) begin
      n_bad++; $display("FAIL rstdiv_add got lat=%0d f=%0d want lat=1 f=7", lat, bus.f);
    end
    handoff("rstdiv");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.oc        = 3'b000;
    bus.a         = 16'h0;
    bus.b         = 16'h0;
    test_reset();
    test_single_cycle_ops();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
